// File: rtl/cache_arbiter_control_pkg.sv
// Shared types for the L1/L2 cache arbiter control.
// Optional round-robin tie-break lives behind CACHE_ARB_ROUND_ROBIN_EN.
package cache_arbiter_control_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_SETUP  = 2'd1,
    ARB_ACCESS = 2'd2,
    ARB_RESP   = 2'd3
  } arb_state_t;

  typedef enum logic {
    ARB_ICACHE = 1'b0,
    ARB_DCACHE = 1'b1
  } arb_owner_t;

  localparam logic [1:0] RSEL_NONE = 2'd0;
  localparam logic [1:0] RSEL_I    = 2'd1;
  localparam logic [1:0] RSEL_D    = 2'd2;

  typedef struct packed {
    arb_owner_t owner;
    logic       write;
  } arb_grant_t;

  function automatic logic [1:0] read_sel_of(input arb_grant_t g);
    if (g.write) return RSEL_NONE;
    return (g.owner == ARB_DCACHE) ? RSEL_D : RSEL_I;
  endfunction

endpackage

// File: rtl/cache_arbiter_control_if.sv
// Request/command bundle between the L1 caches, the arbiter control and L2.
// master = arbiter control, slave = caches/datapath/L2 side.
interface cache_arbiter_control_if;
  logic       icache_read;
  logic       dcache_read;
  logic       dcache_write;
  logic       l2_resp;
  logic       cache_address_sel;
  logic [1:0] cache_read_sel;
  logic       cache_write_sel;
  logic       cache_resp_sel;
  logic       load_mar;
  logic       load_mdr_l1_to_l2;
  logic       load_mdr_l2_to_l1;
  logic       l2_read;
  logic       l2_write;
  logic       busy;

  modport master (
    input  icache_read, dcache_read, dcache_write, l2_resp,
    output cache_address_sel, cache_read_sel, cache_write_sel, cache_resp_sel,
           load_mar, load_mdr_l1_to_l2, load_mdr_l2_to_l1, l2_read, l2_write, busy
  );

  modport slave (
    output icache_read, dcache_read, dcache_write, l2_resp,
    input  cache_address_sel, cache_read_sel, cache_write_sel, cache_resp_sel,
           load_mar, load_mdr_l1_to_l2, load_mdr_l2_to_l1, l2_read, l2_write, busy
  );
endinterface

// File: rtl/cache_arbiter_control_grant.sv
// arb_grant: combinational owner/op pick from the pending L1 requests.
// CACHE_ARB_ROUND_ROBIN_EN swaps the fixed tie-break for last-owner alternation.
module arb_grant
  import cache_arbiter_control_pkg::*;
`ifndef CACHE_ARB_ROUND_ROBIN_EN
  #(parameter bit DCACHE_FIRST = 1'b1)
`endif
(
  input  logic       icache_read,
  input  logic       dcache_read,
  input  logic       dcache_write,
`ifdef CACHE_ARB_ROUND_ROBIN_EN
  input  arb_owner_t last_owner,
`endif
  output arb_grant_t grant
);

  logic       d_req;
  arb_owner_t tie;

  always_comb begin
    d_req = dcache_read | dcache_write;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    tie = (last_owner == ARB_DCACHE) ? ARB_ICACHE : ARB_DCACHE;
`else
    tie = DCACHE_FIRST ? ARB_DCACHE : ARB_ICACHE;
`endif
    if (icache_read && d_req) grant.owner = tie;
    else if (d_req)           grant.owner = ARB_DCACHE;
    else                      grant.owner = ARB_ICACHE;
    // a pending writeback beats a dcache read so the victim leaves before the fill
    grant.write = (grant.owner == ARB_DCACHE) && dcache_write;
  end

endmodule

// File: rtl/cache_arbiter_control.sv
// Sequences the shared L2 port: IDLE -> SETUP -> ACCESS (until l2_resp) -> RESP.
// Build with CACHE_ARB_ROUND_ROBIN_EN for alternating grants on contention.
module cache_arbiter_control
  import cache_arbiter_control_pkg::*;
#(
  parameter bit DCACHE_FIRST = 1'b1
) (
  input logic                     clk,
  input logic                     rst,
  cache_arbiter_control_if.master bus
);

  localparam logic [1:0] ST_IDLE   = ARB_IDLE;
  localparam logic [1:0] ST_SETUP  = ARB_SETUP;
  localparam logic [1:0] ST_ACCESS = ARB_ACCESS;
  localparam logic [1:0] ST_RESP   = ARB_RESP;

  logic [1:0] state;
  arb_grant_t cur;
  arb_grant_t pick;
  logic       any_req;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  arb_owner_t last_owner;

  arb_grant u_grant (
    .icache_read (bus.icache_read),
    .dcache_read (bus.dcache_read),
    .dcache_write(bus.dcache_write),
    .last_owner  (last_owner),
    .grant       (pick)
  );
`else
  arb_grant #(.DCACHE_FIRST(DCACHE_FIRST)) u_grant (
    .icache_read (bus.icache_read),
    .dcache_read (bus.dcache_read),
    .dcache_write(bus.dcache_write),
    .grant       (pick)
  );
`endif

  assign any_req = bus.icache_read | bus.dcache_read | bus.dcache_write;

  // owner/op are captured once in IDLE and frozen until the next IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cur.owner  <= arb_owner_t'(DCACHE_FIRST);
      cur.write  <= 1'b0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      last_owner <= DCACHE_FIRST ? ARB_ICACHE : ARB_DCACHE;
`endif
    end else begin
      case (state)
        ST_IDLE: if (any_req) begin
          state      <= ST_SETUP;
          cur        <= pick;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
          last_owner <= pick.owner;
`endif
        end
        ST_SETUP:  state <= ST_ACCESS;
        ST_ACCESS: if (bus.l2_resp) state <= ST_RESP;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.cache_address_sel = 1'b0;
    bus.cache_read_sel    = RSEL_NONE;
    bus.cache_write_sel   = 1'b0;
    bus.cache_resp_sel    = 1'b0;
    bus.load_mar          = 1'b0;
    bus.load_mdr_l1_to_l2 = 1'b0;
    bus.load_mdr_l2_to_l1 = 1'b0;
    bus.l2_read           = 1'b0;
    bus.l2_write          = 1'b0;
    bus.busy              = 1'b0;
    // selects stay steady from SETUP through RESP so the registered resp routes correctly
    if (state != ST_IDLE) begin
      bus.cache_address_sel = cur.owner;
      bus.cache_read_sel    = read_sel_of(cur);
      bus.cache_write_sel   = cur.write;
      bus.cache_resp_sel    = cur.owner;
      bus.busy              = 1'b1;
    end
    case (state)
      ST_SETUP: begin
        bus.load_mar          = 1'b1;
        bus.load_mdr_l1_to_l2 = cur.write;
      end
      ST_ACCESS: begin
        bus.l2_read           = ~cur.write;
        bus.l2_write          = cur.write;
        bus.load_mdr_l2_to_l1 = ~cur.write;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_arbiter_control.sv
// Bench for cache_arbiter_control: directed scenarios plus random request traffic
// checked against a transaction-level model (honours CACHE_ARB_ROUND_ROBIN_EN).
module tb_cache_arbiter_control;

  localparam bit DF = 1'b1;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  bit   last;

  cache_arbiter_control_if bus();

  cache_arbiter_control #(.DCACHE_FIRST(DF)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] obs();
    return {bus.cache_address_sel, bus.cache_read_sel, bus.cache_write_sel,
            bus.cache_resp_sel, bus.load_mar, bus.load_mdr_l1_to_l2,
            bus.load_mdr_l2_to_l1, bus.l2_read, bus.l2_write, bus.busy};
  endfunction

  // phase: 0 idle, 1 setup, 2 access, 3 resp
  function automatic logic [10:0] exp_vec(input int ph, input bit own, input bit wr);
    logic [1:0] rs;
    if (ph == 0) return 11'd0;
    rs = wr ? 2'd0 : (own ? 2'd2 : 2'd1);
    return {own, rs, wr, own, (ph == 1), (ph == 1 && wr), (ph == 2 && !wr),
            (ph == 2 && !wr), (ph == 2 && wr), 1'b1};
  endfunction

  task automatic check(input string tag, input logic [10:0] exp);
    logic [10:0] o;
    o = obs();
    total++;
    assert (o === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, o, exp);
    end
  endtask

  // {owner, write} the arbiter should grant given the currently pending requests
  function automatic logic [1:0] model_pick();
    bit i, d, o;
    i = bus.icache_read;
    d = bus.dcache_read | bus.dcache_write;
    if (i && d) o = RR ? !last : DF;
    else        o = d;
    return {o, o & bus.dcache_write};
  endfunction

  task automatic raise_any();
    case ($urandom_range(0, 2))
      0:       bus.icache_read  = 1'b1;
      1:       bus.dcache_read  = 1'b1;
      default: bus.dcache_write = 1'b1;
    endcase
  endtask

  // mode: 0 plain, 1 random late requests, 2 icache drops / dcache rises in ACCESS
  task automatic do_txn(input string tag, input bit own, input bit wr, input int lat, input int mode);
    step();
    check({tag, ".setup"}, exp_vec(1, own, wr));
    for (int k = 0; k < lat; k++) begin
      step();
      check({tag, ".access"}, exp_vec(2, own, wr));
      if (mode == 2 && k == 0) begin
        bus.icache_read = 1'b0;
        bus.dcache_read = 1'b1;
      end
      if (mode == 1 && $urandom_range(0, 3) == 0) raise_any();
      bus.l2_resp = (k == lat - 1);
    end
    step();
    bus.l2_resp = 1'b0;
    check({tag, ".resp"}, exp_vec(3, own, wr));
    step();
    if (!own)    bus.icache_read  = 1'b0;
    else if (wr) bus.dcache_write = 1'b0;
    else         bus.dcache_read  = 1'b0;
    check({tag, ".idle"}, 11'd0);
    last = own;
  endtask

  initial begin
    logic [1:0] g;
    rst = 1'b1;
    bus.icache_read  = 1'b0;
    bus.dcache_read  = 1'b0;
    bus.dcache_write = 1'b0;
    bus.l2_resp      = 1'b0;
    step();
    step();
    check("reset", 11'd0);
    rst  = 1'b0;
    last = !DF;

    // lone icache read, five ACCESS cycles
    bus.icache_read = 1'b1;
    do_txn("iread", 1'b0, 1'b0, 5, 0);

    // writeback wins over the read, read follows
    bus.dcache_write = 1'b1;
    bus.dcache_read  = 1'b1;
    do_txn("wr_first", 1'b1, 1'b1, 2, 0);
    do_txn("rd_second", 1'b1, 1'b0, 3, 0);

    // both caches contend continuously after a fresh reset
    rst = 1'b1;
    step();
    check("reset2", 11'd0);
    rst  = 1'b0;
    last = !DF;
    for (int k = 0; k < 4; k++) begin
      bus.icache_read = 1'b1;
      bus.dcache_read = 1'b1;
      do_txn($sformatf("alt%0d", k), RR ? (k % 2 == 0) : 1'b1, 1'b0, 1 + k, 0);
    end
    bus.icache_read = 1'b0;
    bus.dcache_read = 1'b0;

    // request changes mid-transaction are ignored until IDLE
    bus.icache_read = 1'b1;
    do_txn("drop_i", 1'b0, 1'b0, 3, 2);
    do_txn("then_d", 1'b1, 1'b0, 2, 0);

    // reset while in ACCESS abandons the transaction
    bus.icache_read = 1'b1;
    step();
    check("rst_setup", exp_vec(1, 1'b0, 1'b0));
    step();
    check("rst_access", exp_vec(2, 1'b0, 1'b0));
    rst = 1'b1;
    step();
    check("rst_mid", 11'd0);
    rst  = 1'b0;
    last = !DF;
    do_txn("after_rst", 1'b0, 1'b0, 2, 0);

    // random traffic
    for (int n = 0; n < 40; n++) begin
      if (!(bus.icache_read | bus.dcache_read | bus.dcache_write) || $urandom_range(0, 1) == 1) begin
        bus.icache_read  = bus.icache_read  | 1'($urandom_range(0, 1));
        bus.dcache_read  = bus.dcache_read  | 1'($urandom_range(0, 1));
        bus.dcache_write = bus.dcache_write | 1'($urandom_range(0, 1));
      end
      if (!(bus.icache_read | bus.dcache_read | bus.dcache_write)) bus.icache_read = 1'b1;
      g = model_pick();
      do_txn($sformatf("rnd%0d", n), g[1], g[0], $urandom_range(1, 4), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_arbiter_control.md
Name: cache_arbiter_control

Overview:
- FSM that sequences cache_arbiter_datapath and shares one L2 port between the L1 icache (read-only) and the L1 dcache (read/write).
- Picks one requester, holds the datapath selects steady, and drives l2_read/l2_write directly to L2.
- Respects the datapath's registered MAR/MDR and its one-cycle registered response path.

Parameters:
- DCACHE_FIRST, 1: tie-break when both request (fixed-priority winner; round-robin initial winner after reset). 1 = dcache, 0 = icache.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- icache_read  in  1  icache read request (level, held until icache_resp)
- dcache_read  in  1  dcache read request
- dcache_write  in  1  dcache writeback request
- l2_resp  in  1  L2 completion pulse
- cache_address_sel  out  1  0 = icache address, 1 = dcache address
- cache_read_sel  out  2  0 none, 1 icache, 2 dcache
- cache_write_sel  out  1  1 = dcache write owns the port
- cache_resp_sel  out  1  0 = route resp to icache, 1 = dcache
- load_mar  out  1  MAR load strobe
- load_mdr_l1_to_l2  out  1  write-data register load strobe
- load_mdr_l2_to_l1  out  1  read-data register load strobe
- l2_read  out  1  L2 read command
- l2_write  out  1  L2 write command
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE, owner = DCACHE_FIRST, all outputs 0.
- Reset mid-transaction abandons the transaction; L2 is reset in the same cycle.
- States:
  - IDLE: nothing pending -> stay, all outputs 0. Any request -> latch owner and op, go to SETUP.
  - Dcache op: write wins if dcache_read and dcache_write are both high.
- Owner selection when both caches pend:
  - Fixed priority: DCACHE_FIRST decides.
  - Round-robin (optional feature): see below.
- SETUP (1 cycle):
  - cache_address_sel = owner; load_mar = 1.
  - load_mdr_l1_to_l2 = 1 for a write.
  - l2_read and l2_write both 0, because the MAR output is only valid next cycle.
  - Next state: ACCESS.
- ACCESS:
  - Select outputs keep the same values as in SETUP; strobes load_mar and load_mdr_l1_to_l2 drop to 0.
  - l2_read = 1 (read op) or l2_write = 1 (write op); cache_read_sel and cache_write_sel encode the op.
  - cache_resp_sel = owner throughout, so resp_sel_reg is correct when the registered response emerges.
  - load_mdr_l2_to_l1 = 1 on a read.
  - l2_resp = 1 -> l2_read and l2_write are still asserted this cycle; go to RESP. Otherwise wait indefinitely (no timeout).
- RESP (1 cycle):
  - l2_read = l2_write = 0; cache_resp_sel held.
  - The datapath presents the registered resp and rdata to the owner this cycle.
  - Next state: IDLE.
- Owner L1 deasserts its request in the cycle after RESP, so IDLE never re-grants a stale request.
- Minimum occupancy: 3 cycles plus L2 latency. Back-to-back grants allowed (IDLE -> SETUP with no idle gap beyond the one IDLE cycle).
- The latched owner and op are fixed for the whole transaction. Request deassertion or a new request mid-transaction is ignored until IDLE.
- icache_write does not exist; icache never causes l2_write.

Optional Feature:
- Macro: CACHE_ARB_ROUND_ROBIN_EN.
- Defined:
  - On a simultaneous request, grant the requester that did not own the last transaction.
  - A 1-bit last_owner register, reset to !DCACHE_FIRST, updates on every grant.
  - A dcache write-then-read pair counts as two dcache grants, so icache gets the slot between them if it is pending.
- Undefined: fixed priority per DCACHE_FIRST; no last_owner register.

Decomposition:
- lc3b_types gains:
  - enum arb_state_t {ARB_IDLE, ARB_SETUP, ARB_ACCESS, ARB_RESP}
  - enum arb_owner_t {ARB_ICACHE = 1'b0, ARB_DCACHE = 1'b1}
  - read-select constants RSEL_NONE = 2'd0, RSEL_I = 2'd1, RSEL_D = 2'd2
- One sub-module: arb_grant. Combinational pick of owner and op from the requests, last_owner and DCACHE_FIRST; contains the CACHE_ARB_ROUND_ROBIN_EN logic.

Test Plan:
- icache_read only, l2_resp 4 cycles after ACCESS entry -> address_sel = 0, l2_read high for 5 cycles, icache_resp pulses 1 cycle after l2_resp, dcache_resp = 0.
- dcache_write and dcache_read together, then read only after resp -> write transaction first (l2_write = 1, load_mdr_l1_to_l2 in SETUP), then read transaction; l2_write = 0 throughout the read.
- icache_read and dcache_read held simultaneously, DCACHE_FIRST = 1:
  - Macro off -> dcache, dcache, ...
  - Macro on -> dcache, icache, dcache alternating grants.
- icache_read drops in ACCESS and dcache_read rises -> icache transaction completes unchanged; dcache is granted only after RESP -> IDLE.
- rst asserted in ACCESS -> next cycle all outputs 0, state IDLE, busy = 0; a subsequent request proceeds normally.
